// File: rtl/dp_pkg.sv
// dp_pkg: shared encodings and reset constants for the 8-bit microcontroller datapath.
package dp_pkg;
   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_SHL = 4'd2,
      ALU_SHR = 4'd3,
      ALU_AND = 4'd4,
      ALU_OR  = 4'd5,
      ALU_XOR = 4'd6,
      ALU_INC = 4'd7,
      ALU_DEC = 4'd8
   } alu_op_e;
   typedef enum logic [1:0] {B1_PC = 2'd0, B1_A = 2'd1, B1_B = 2'd2, B1_ZERO = 2'd3} bus1_sel_e;
   typedef enum logic [1:0] {B2_ALU = 2'd0, B2_BUS1 = 2'd1, B2_MEM = 2'd2, B2_ZERO = 2'd3} bus2_sel_e;
   localparam int CCR_C = 0;
   localparam int CCR_V = 1;
   localparam int CCR_Z = 2;
   localparam int CCR_N = 3;
   localparam logic [7:0] RST_BYTE = 8'h00;
   localparam logic [3:0] RST_CCR  = 4'b0000;
endpackage

// File: rtl/data_path_if.sv
// data_path_if: control-unit strobes and memory-side signals of the datapath.
interface data_path_if;
   logic       IR_Load, MAR_Load, PC_Load, PC_Inc;
   logic [3:0] reg_read_addr_A, reg_read_addr_B, reg_write_addr;
   logic       reg_write_enable;
   logic [3:0] ALU_Sel;
   logic       CCR_Load;
   logic [1:0] Bus1_Sel, Bus2_Sel;
   logic       ALU_B_Sel;
   logic [7:0] from_memory;
   logic [7:0] address, to_memory, IR;
   logic [3:0] CCR_Result;
   modport master (
      output IR_Load, MAR_Load, PC_Load, PC_Inc, reg_read_addr_A, reg_read_addr_B, reg_write_addr,
             reg_write_enable, ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, ALU_B_Sel, from_memory,
      input  address, to_memory, IR, CCR_Result
   );
   modport slave (
      input  IR_Load, MAR_Load, PC_Load, PC_Inc, reg_read_addr_A, reg_read_addr_B, reg_write_addr,
             reg_write_enable, ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, ALU_B_Sel, from_memory,
      output address, to_memory, IR, CCR_Result
   );
endinterface

// File: rtl/dp_alu.sv
// dp_alu: combinational 8-bit ALU with NZVC flags; shift ops 2/3 exist only under DATAPATH_SHIFT_OPS_EN.
module dp_alu
   import dp_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [3:0] alu_sel,
   output logic [7:0] r,
   output logic [3:0] nzvc,
   output logic       ok
);
   logic c, v;
   always_comb begin
      r  = 8'h00;
      c  = 1'b0;
      v  = 1'b0;
      ok = 1'b1;
      case (alu_sel)
         ALU_ADD: begin
            {c, r} = {1'b0, a} + {1'b0, b};
            v = (a[7] == b[7]) && (r[7] != a[7]);
         end
         ALU_SUB: begin
            {c, r} = {1'b0, a} - {1'b0, b};
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
`ifdef DATAPATH_SHIFT_OPS_EN
         ALU_SHL: begin
            r = {a[6:0], 1'b0};
            c = a[7];
         end
         ALU_SHR: begin
            r = {1'b0, a[7:1]};
            c = a[0];
         end
`endif
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         ALU_INC: begin
            r = a + 8'd1;
            c = a == 8'hFF;
            v = a == 8'h7F;
         end
         ALU_DEC: begin
            r = a - 8'd1;
            c = a == 8'h00;
            v = a == 8'h80;
         end
         default: ok = 1'b0;
      endcase
   end
   assign nzvc = {r[7], r == 8'h00, v, c};
endmodule

// File: rtl/data_path.sv
// data_path: PC/MAR/IR, 16x8 register file, CCR, Bus1/Bus2 muxes and ALU of the microcontroller.
// Build option: DATAPATH_SHIFT_OPS_EN enables ALU shift ops (handled in dp_alu).
module data_path
   import dp_pkg::*;
(
   input logic       clk,
   input logic       reset,
   data_path_if.slave bus
);
   logic [7:0] pc_q, pc_d, mar_q, mar_d, ir_q, ir_d;
   logic [3:0] ccr_q, ccr_d;
   logic [7:0] rf_q [16];
   logic [7:0] rf_d [16];
   logic [7:0] reg_a, reg_b, bus1, bus2_ext, bus2, alu_b, alu_r;
   logic [3:0] alu_nzvc;
   logic       alu_ok;
   assign reg_a = rf_q[bus.reg_read_addr_A];
   assign reg_b = rf_q[bus.reg_read_addr_B];
   assign bus1  = bus.Bus1_Sel == B1_PC ? pc_q :
                  bus.Bus1_Sel == B1_A  ? reg_a :
                  bus.Bus1_Sel == B1_B  ? reg_b : 8'h00;
   // ALU operand B never sees the ALU's own result, which would form a combinational loop.
   assign bus2_ext = bus.Bus2_Sel == B2_BUS1 ? bus1 :
                     bus.Bus2_Sel == B2_MEM  ? bus.from_memory : 8'h00;
   assign bus2  = bus.Bus2_Sel == B2_ALU ? alu_r : bus2_ext;
   assign alu_b = bus.ALU_B_Sel ? bus2_ext : reg_b;
   dp_alu u_alu (
      .a      (bus1),
      .b      (alu_b),
      .alu_sel(bus.ALU_Sel),
      .r      (alu_r),
      .nzvc   (alu_nzvc),
      .ok     (alu_ok)
   );
   always_comb begin
      pc_d  = bus.PC_Load ? (bus.ALU_B_Sel ? alu_r : bus2) : bus.PC_Inc ? pc_q + 8'd1 : pc_q;
      mar_d = bus.MAR_Load ? bus2 : mar_q;
      ir_d  = bus.IR_Load ? bus2 : ir_q;
      ccr_d = bus.CCR_Load && alu_ok ? alu_nzvc : ccr_q;
      rf_d  = rf_q;
      if (bus.reg_write_enable) rf_d[bus.reg_write_addr] = bus2;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= RST_BYTE;
         mar_q <= RST_BYTE;
         ir_q  <= RST_BYTE;
         ccr_q <= RST_CCR;
         rf_q  <= '{default: RST_BYTE};
      end else begin
         pc_q  <= pc_d;
         mar_q <= mar_d;
         ir_q  <= ir_d;
         ccr_q <= ccr_d;
         rf_q  <= rf_d;
      end
   end
   assign bus.address    = mar_q;
   assign bus.to_memory  = bus1;
   assign bus.IR         = ir_q;
   assign bus.CCR_Result = ccr_q;
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed vectors with a queue scoreboard checked by a negedge monitor.
module tb_data_path;
   logic clk = 1'b0;
   logic reset;
   data_path_if dif();
   data_path dut (.clk(clk), .reset(reset), .bus(dif));
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      int         kind;
      logic [7:0] exp;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   logic [7:0] mon_obs;
   int tests = 0;
   int fails = 0;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         mon_obs = mon_e.kind == 0 ? dif.address :
                   mon_e.kind == 1 ? dif.IR :
                   mon_e.kind == 2 ? dif.to_memory : {4'h0, dif.CCR_Result};
         tests++;
         if (mon_obs !== mon_e.exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", mon_e.name, mon_obs, mon_e.exp);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dif.IR_Load = 0; dif.MAR_Load = 0; dif.PC_Load = 0; dif.PC_Inc = 0;
      dif.reg_read_addr_A = 0; dif.reg_read_addr_B = 0; dif.reg_write_addr = 0;
      dif.reg_write_enable = 0; dif.ALU_Sel = 0; dif.CCR_Load = 0;
      dif.Bus1_Sel = 0; dif.Bus2_Sel = 0; dif.ALU_B_Sel = 0; dif.from_memory = 0;
   endtask

   task automatic chk(input string n, input int k, input logic [7:0] v);
      sb.push_back('{n, k, v});
      step();
   endtask

   task automatic rd(input string n, input logic [3:0] a, input logic [7:0] v);
      dif.Bus1_Sel = 2'd1;
      dif.reg_read_addr_A = a;
      chk(n, 2, v);
      idle();
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] v);
      dif.from_memory = v; dif.Bus2_Sel = 2'd2;
      dif.reg_write_addr = a; dif.reg_write_enable = 1;
      step();
      idle();
   endtask

   task automatic alu_wr(input logic [3:0] sel, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] wa);
      dif.Bus1_Sel = 2'd1; dif.reg_read_addr_A = ra; dif.reg_read_addr_B = rb;
      dif.ALU_Sel = sel; dif.Bus2_Sel = 2'd0; dif.ALU_B_Sel = 0;
      dif.reg_write_addr = wa; dif.reg_write_enable = 1; dif.CCR_Load = 1;
      step();
      idle();
   endtask

   task automatic pc_set(input logic [7:0] v);
      dif.from_memory = v; dif.Bus2_Sel = 2'd2; dif.PC_Load = 1;
      step();
      idle();
   endtask

   task automatic branch(input logic [7:0] off, input logic inc);
      dif.from_memory = off; dif.Bus2_Sel = 2'd2; dif.ALU_B_Sel = 1;
      dif.ALU_Sel = 4'd0; dif.PC_Load = 1; dif.PC_Inc = inc;
      step();
      idle();
   endtask

   initial begin
      reset = 0;
      idle();
      step();
      chk("rst_address", 0, 8'h00);
      chk("rst_ir", 1, 8'h00);
      chk("rst_ccr", 3, 8'h00);
      chk("rst_to_memory", 2, 8'h00);
      reset = 1;
      step();
      dif.PC_Inc = 1;
      step();
      idle();
      dif.MAR_Load = 1; dif.Bus2_Sel = 2'd1;
      step();
      idle();
      chk("mar_pc_plus1", 0, 8'h01);
      dif.from_memory = 8'h90; dif.Bus2_Sel = 2'd2; dif.IR_Load = 1;
      step();
      idle();
      chk("ir_load", 1, 8'h90);
      wr(4'd3, 8'h90);
      rd("r3_write", 4'd3, 8'h90);
      wr(4'd1, 8'h7F);
      wr(4'd2, 8'h01);
      alu_wr(4'd0, 4'd1, 4'd2, 4'd1);
      rd("add_result", 4'd1, 8'h80);
      chk("add_ccr", 3, 8'h0A);
      alu_wr(4'd1, 4'd1, 4'd2, 4'd1);
      rd("sub_result", 4'd1, 8'h7F);
      chk("sub_ccr", 3, 8'h02);
      wr(4'd4, 8'h00);
      alu_wr(4'd8, 4'd4, 4'd0, 4'd4);
      rd("dec_result", 4'd4, 8'hFF);
      chk("dec_ccr", 3, 8'h09);
      alu_wr(4'd7, 4'd4, 4'd0, 4'd4);
      rd("inc_result", 4'd4, 8'h00);
      chk("inc_ccr", 3, 8'h05);
      pc_set(8'hFE);
      chk("pc_load_bus2", 2, 8'hFE);
      branch(8'h05, 1'b0);
      chk("pc_branch_wrap", 2, 8'h03);
      pc_set(8'hFE);
      branch(8'h05, 1'b1);
      chk("pc_load_over_inc", 2, 8'h03);
      pc_set(8'hFF);
      dif.PC_Inc = 1;
      step();
      idle();
      chk("pc_inc_wrap", 2, 8'h00);
      wr(4'd5, 8'hA5);
      rd("st_path", 4'd5, 8'hA5);
      wr(4'd6, 8'h81);
      alu_wr(4'd4, 4'd5, 4'd6, 4'd8);
      rd("and_result", 4'd8, 8'h81);
      chk("and_ccr", 3, 8'h08);
      wr(4'd7, 8'h33);
      alu_wr(4'd2, 4'd6, 4'd0, 4'd7);
`ifdef DATAPATH_SHIFT_OPS_EN
      rd("shl_result", 4'd7, 8'h02);
      chk("shl_ccr", 3, 8'h01);
`else
      rd("op2_result", 4'd7, 8'h00);
      chk("op2_ccr_hold", 3, 8'h08);
`endif
      wr(4'd9, 8'h44);
      alu_wr(4'd9, 4'd6, 4'd0, 4'd9);
      rd("op9_result", 4'd9, 8'h00);
`ifdef DATAPATH_SHIFT_OPS_EN
      chk("op9_ccr_hold", 3, 8'h01);
`else
      chk("op9_ccr_hold", 3, 8'h08);
`endif
      reset = 0;
      chk("async_rst_address", 0, 8'h00);
      chk("async_rst_ir", 1, 8'h00);
      reset = 1;
      repeat (3) step();
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/data_path.md
# data_path

Datapath for the 8-bit microcontroller, driven cycle-by-cycle by the control unit's strobes. Holds PC, MAR, IR, the 16×8 register file and the CCR, and builds the two internal buses and the ALU. It feeds IR and CCR_Result back to the control unit and presents address and write data to memory. The memory `write` strobe bypasses this block.

## Interface
- No parameters; widths fixed at 8-bit data/address, 16 registers.
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low
- IR_Load, MAR_Load, PC_Load, PC_Inc  in  1 each  register load/increment strobes
- reg_read_addr_A, reg_read_addr_B  in  4 each  register-file read ports
- reg_write_addr  in  4  register-file write address
- reg_write_enable  in  1  register-file write strobe
- ALU_Sel  in  4  ALU operation
- CCR_Load  in  1  latch ALU flags into CCR
- Bus1_Sel, Bus2_Sel  in  2 each  bus source selects
- ALU_B_Sel  in  1  ALU B operand: 0 = reg B, 1 = Bus2
- from_memory  in  8  memory read data
- address  out  8  MAR contents
- to_memory  out  8  Bus1, combinational
- IR  out  8  instruction register
- CCR_Result  out  4  {N,Z,V,C} in bits [3:0]

## Operation
- Bus1 mux: 00 PC, 01 reg A, 10 reg B, 11 8'h00.
- Bus2 mux: 00 ALU result, 01 Bus1, 10 from_memory, 11 8'h00.
- ALU A = Bus1. ALU B = reg B when ALU_B_Sel=0; Bus2 when ALU_B_Sel=1.
- Loads:
  - MAR and IR load from Bus2.
  - Register-file write data is Bus2.
  - PC_Load loads the ALU result when ALU_B_Sel=1 (branch PC+offset); otherwise Bus2.
- PC arithmetic:
  - PC_Inc adds 1, wrapping 8'hFF → 8'h00.
  - PC_Load has priority over PC_Inc.
  - A branch offset is unsigned 8-bit; the sum wraps modulo 256.
- ALU ops (result R, 8-bit):
  - 0 ADD: C = carry out; V = (A7==B7)&&(R7!=A7).
  - 1 SUB: R = A−B; C = borrow (A<B unsigned); V = (A7!=B7)&&(R7!=A7).
  - 4 AND, 5 OR, 6 XOR: C = 0, V = 0.
  - 7 INC (A+1): C = (A==8'hFF); V = (A==8'h7F).
  - 8 DEC (A−1): C = (A==8'h00); V = (A==8'h80).
  - All ops: N = R7, Z = (R==0).
  - Any other code: R = 8'h00 and CCR holds even if CCR_Load=1. Codes 2/3 are covered under Configuration.
- Register file: two asynchronous read ports, one synchronous write port.
  - A read of the address being written returns the old value that cycle.
  - Register 0 is an ordinary register.

## Timing
- Reset: PC, MAR, IR, all 16 registers = 8'h00; CCR = 4'b0000.
  - Hence address = 8'h00 and IR = 8'h00 during reset.
  - to_memory follows Bus1; with all-zero selects it reads PC = 8'h00.
- Every strobe takes effect at the next rising edge. New register values are visible on outputs the same cycle after that edge.
- Flags are computed combinationally from the same-cycle operands and latched on the edge where CCR_Load=1.
- Simultaneous MAR_Load, IR_Load, PC_Load and reg_write_enable are legal. All sample the pre-edge Bus2/ALU value.
- Reset asserted mid-instruction clears state immediately (asynchronous). Deassertion is synchronized externally.

## Configuration
- DATAPATH_SHIFT_OPS_EN defined:
  - ALU_Sel 2 = SHL: R = A<<1, C = A7.
  - ALU_Sel 3 = SHR logical: R = A>>1, C = A0.
  - Both set V = 0; N and Z follow the usual rules.
- Undefined: codes 2/3 follow the "other code" rule (R = 0, CCR holds).

## Structure
- Package dp_pkg holds:
  - ALU op encodings
  - Bus1/Bus2 select encodings
  - CCR bit indices (C=0, V=1, Z=2, N=3)
  - Reset constants
- Combinational sub-module dp_alu: inputs A, B, ALU_Sel; outputs R, NZVC and a valid-op flag that gates CCR_Load. The top level holds all registers and muxes.

## Test plan
- Reset then release: address=00, IR=00, CCR=0000. One PC_Inc, then MAR_Load with Bus1_Sel=00/Bus2_Sel=01 → address=01.
- from_memory=8'h90, Bus2_Sel=10, IR_Load → IR=90. Same setup with reg_write_addr=3 and reg_write_enable → R3=90.
- R1=7F, R2=01, ADD (sel 0, B from reg, Bus2=ALU, write R1, CCR_Load) → R1=80, NZVC=1010. Then SUB R1-R2 → 7F, NZVC=0010.
- R4=00, DEC with CCR_Load → R4=FF, NZVC=1001. INC of R4 → 00, NZVC=0101.
- PC=FE, from_memory=05, Bus1_Sel=00, Bus2_Sel=10, ALU_B_Sel=1, ALU_Sel=0, PC_Load → PC=03 (wrap). The same cycle with PC_Inc also set → still 03.
- ST path: R5=A5, Bus1_Sel=01, reg_read_addr_A=5 → to_memory=A5. ALU_Sel=2 with CCR_Load: R=00 and CCR unchanged without DATAPATH_SHIFT_OPS_EN; with it, A=81 gives R=02, NZVC=0001.
